// File: rtl/fm_modulator.sv
// fm_modulator
//   Direct-digital FM carrier generator. A baseband message is captured once
//   every 2^sample_rate clocks. The held sample is scaled by 2^dev_shift and
//   added to the carrier phase increment. A free-running 32-bit phase
//   accumulator integrates that increment. Its top 8 bits address a
//   quarter-wave sine table to produce the output.
//
// Ports
//   clk           in   1  rising-edge clock
//   rst           in   1  synchronous active-high reset
//   modulating    in  16  signed baseband message
//   ctr_ctrl      in  32  carrier phase increment per clock (unsigned)
//   dev_shift     in   5  deviation scale, values above 16 behave as 16
//   sample_rate   in   5  message capture period is 2^sample_rate clocks
//   modulated     out 16  signed sine output, range [-32767, 32767]
//   phase         out 32  phase accumulator value
//   sample_strobe out  1  one-cycle pulse following each message capture
//
// Latency: a message captured at edge E reaches the frequency word at E+1,
// the phase at E+2 and the output at E+3.

module fm_modulator (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] modulating,
    input  logic [31:0] ctr_ctrl,
    input  logic [4:0]  dev_shift,
    input  logic [4:0]  sample_rate,
    output logic [15:0] modulated,
    output logic [31:0] phase,
    output logic        sample_strobe
);

    localparam int DATA_W = 16;  // message and output sample width
    localparam int COEF_W = 32;  // frequency word and phase width

    // Quarter-wave table: round(32767 * sin(2*pi*k/256)), k = 0..64.
    function automatic logic [DATA_W-1:0] quarter_sin(input logic [6:0] idx);
        logic [DATA_W-1:0] v;
        case (idx)
            7'd0:  v = 16'd0;     7'd1:  v = 16'd804;   7'd2:  v = 16'd1608;
            7'd3:  v = 16'd2410;  7'd4:  v = 16'd3212;  7'd5:  v = 16'd4011;
            7'd6:  v = 16'd4808;  7'd7:  v = 16'd5602;  7'd8:  v = 16'd6393;
            7'd9:  v = 16'd7179;  7'd10: v = 16'd7962;  7'd11: v = 16'd8739;
            7'd12: v = 16'd9512;  7'd13: v = 16'd10278; 7'd14: v = 16'd11039;
            7'd15: v = 16'd11793; 7'd16: v = 16'd12539; 7'd17: v = 16'd13279;
            7'd18: v = 16'd14010; 7'd19: v = 16'd14732; 7'd20: v = 16'd15446;
            7'd21: v = 16'd16151; 7'd22: v = 16'd16846; 7'd23: v = 16'd17530;
            7'd24: v = 16'd18204; 7'd25: v = 16'd18868; 7'd26: v = 16'd19519;
            7'd27: v = 16'd20159; 7'd28: v = 16'd20787; 7'd29: v = 16'd21403;
            7'd30: v = 16'd22005; 7'd31: v = 16'd22594; 7'd32: v = 16'd23170;
            7'd33: v = 16'd23731; 7'd34: v = 16'd24279; 7'd35: v = 16'd24811;
            7'd36: v = 16'd25329; 7'd37: v = 16'd25832; 7'd38: v = 16'd26319;
            7'd39: v = 16'd26790; 7'd40: v = 16'd27245; 7'd41: v = 16'd27683;
            7'd42: v = 16'd28105; 7'd43: v = 16'd28510; 7'd44: v = 16'd28898;
            7'd45: v = 16'd29268; 7'd46: v = 16'd29621; 7'd47: v = 16'd29956;
            7'd48: v = 16'd30273; 7'd49: v = 16'd30571; 7'd50: v = 16'd30852;
            7'd51: v = 16'd31113; 7'd52: v = 16'd31356; 7'd53: v = 16'd31580;
            7'd54: v = 16'd31785; 7'd55: v = 16'd31971; 7'd56: v = 16'd32137;
            7'd57: v = 16'd32285; 7'd58: v = 16'd32412; 7'd59: v = 16'd32521;
            7'd60: v = 16'd32609; 7'd61: v = 16'd32678; 7'd62: v = 16'd32728;
            7'd63: v = 16'd32757; 7'd64: v = 16'd32767;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    // Full-wave sine from the top 8 phase bits. Odd quadrants mirror the
    // table index and the lower half-cycle negates it. The table peaks at
    // 32767, so negation can never overflow.
    function automatic logic signed [DATA_W-1:0] sin_lut(input logic [7:0] ph);
        logic [1:0]        quad;
        logic [5:0]        ofs;
        logic [6:0]        idx;
        logic signed [DATA_W-1:0] mag;
        quad = ph[7:6];
        ofs  = ph[5:0];
        idx  = quad[0] ? (7'd64 - {1'b0, ofs}) : {1'b0, ofs};
        mag  = signed'(quarter_sin(idx));
        return quad[1] ? -mag : mag;
    endfunction

    logic [30:0]              cnt_p0;
    logic [30:0]              term;
    logic                     capture;
    logic                     vld_p0;
    logic signed [DATA_W-1:0] hold_p0;
    logic signed [COEF_W-1:0] hold_ext;
    logic [4:0]               shift_amt;
    logic [COEF_W-1:0]        freq_p1;
    logic [COEF_W-1:0]        phase_p2;
    logic signed [DATA_W-1:0] modulated_p3;

    // Terminal count 2^sample_rate - 1. Computing it in 32 bits and
    // truncating makes sample_rate = 31 give all ones.
    assign term      = 31'((32'd1 << sample_rate) - 32'd1);
    // ">=" rather than "==" so that shrinking sample_rate below the current
    // count forces a capture on the very next edge.
    assign capture   = (cnt_p0 >= term);
    assign shift_amt = (dev_shift > 5'd16) ? 5'd16 : dev_shift;
    assign hold_ext  = COEF_W'(hold_p0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0       <= '0;
            vld_p0       <= 1'b0;
            hold_p0      <= '0;
            freq_p1      <= '0;
            phase_p2     <= '0;
            modulated_p3 <= '0;
        end else begin
            // p0: message capture every 2^sample_rate clocks
            cnt_p0 <= capture ? '0 : cnt_p0 + 31'd1;
            vld_p0 <= capture;
            if (capture) begin
                hold_p0 <= signed'(modulating);
            end
            // p1: instantaneous frequency word, wraps modulo 2^32
            freq_p1 <= ctr_ctrl + COEF_W'(hold_ext <<< shift_amt);
            // p2: phase integration, free wrap
            phase_p2 <= phase_p2 + freq_p1;
            // p3: phase-to-amplitude lookup
            modulated_p3 <= sin_lut(phase_p2[31:24]);
        end
    end

    assign modulated     = modulated_p3;
    assign phase         = phase_p2;
    assign sample_strobe = vld_p0;

endmodule
